// File: rtl/mpu_matrix_loader.sv
// Byte-stream loader that assembles two DIM x DIM operand matrices (A then B) for the MPU adder.
// Optional synchronous abort input `clear` is present only when MPU_LOADER_CLEAR_EN is defined.
module mpu_matrix_loader #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ELEM_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DIM*DIM*ELEM_W-1:0] matrix_a,
    output logic [DIM*DIM*ELEM_W-1:0] matrix_b,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MPU_LOADER_CLEAR_EN
    ,
    input  logic                      clear
`endif
);
    localparam int N     = DIM * DIM;
    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, PRESENT} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             abort;
    logic             last;
    logic             write_a;
    logic             write_b;
    int               pos;

`ifdef MPU_LOADER_CLEAR_EN
    assign abort = clear;
`else
    assign abort = 1'b0;
`endif

    assign in_ready = (state != PRESENT);
    assign accept   = in_valid & in_ready;
    assign last     = (idx == IDX_W'(N - 1));
    assign write_a  = accept & ~abort & (state == LOAD_A);
    assign write_b  = accept & ~abort & (state == LOAD_B);

    // Row-major stream element k = (i, j) lands at slot i + DIM*j of the adder's layout.
    always_comb begin
        pos = (int'(idx) % DIM) * DIM + int'(idx) / DIM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            idx       <= '0;
            out_valid <= 1'b0;
        end else if (abort) begin
            state     <= LOAD_A;
            idx       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (accept) begin
                        if (last) begin
                            idx   <= '0;
                            state <= LOAD_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        if (last) begin
                            idx       <= '0;
                            state     <= PRESENT;
                            out_valid <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        state     <= LOAD_A;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= LOAD_A;
                    idx       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Elements are only ever overwritten, so old contents persist until the next load reaches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix_a <= '0;
            matrix_b <= '0;
        end else begin
            for (int e = 0; e < N; e++) begin
                if (write_a && (e == pos)) matrix_a[e*ELEM_W +: ELEM_W] <= in_data;
                if (write_b && (e == pos)) matrix_b[e*ELEM_W +: ELEM_W] <= in_data;
            end
        end
    end
endmodule
